// File: rtl/rc4_pkg.sv
// RC4 shared types and constants.
// Used by the key schedule and its key byte selector.
package rc4_pkg;

    localparam int S_SIZE            = 256;
    localparam int RAM_RD_LAT        = 2;
    localparam int KEY_BYTES_DEFAULT = 3;
    localparam int KEY_MAX_W         = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_I,
        ST_WAIT_I,
        ST_CAP_I,
        ST_RD_J,
        ST_WAIT_J,
        ST_CAP_J,
        ST_WR_I,
        ST_WR_J,
        ST_DONE
    } ksa_state_t;

    // Key is left-justified, byte 0 at the MSB end.
    function automatic logic [7:0] key_byte(
        input logic [KEY_MAX_W-1:0] key,
        input logic [4:0]           idx
    );
        return key[KEY_MAX_W-8-8*int'(idx) +: 8];
    endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// RC4 key byte selector.
// Registered mod-KEY_BYTES index plus byte mux.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int KEY_W     = 8 * KEY_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       kbyte
);

    localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [IW-1:0]        idx;
    logic [KEY_MAX_W-1:0] key_la;

    // Index tracks i mod KEY_BYTES without a divider.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
        end else if (advance) begin
            if (idx == IW'(KEY_BYTES - 1))
                idx <= '0;
            else
                idx <= idx + 1'b1;
        end
    end

    // Left-justify so byte 0 is always the top byte.
    always_comb begin
        key_la = KEY_MAX_W'(key) << (KEY_MAX_W - KEY_W);
    end

    assign kbyte = key_byte(key_la, 5'(idx));

endmodule

// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling stage driving the shared S RAM.
// Optional cycle counter: RC4_KSA_CYCLE_COUNT_EN.
module rc4_key_schedule
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int KEY_W     = 8 * KEY_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] secret_key,
    input  logic [7:0]       q_data,
    output logic [7:0]       address,
    output logic [7:0]       data,
    output logic             wen,
    output logic             ksa_mem_handler,
    output logic             finish
`ifdef RC4_KSA_CYCLE_COUNT_EN
    ,
    output logic [15:0]      cycle_count
`endif
);

    localparam logic [7:0] I_LAST = 8'(S_SIZE - 1);

    ksa_state_t       state;
    logic [7:0]       i;
    logic [7:0]       j;
    logic [7:0]       si;
    logic [7:0]       sj;
    logic [KEY_W-1:0] key_q;
    logic [7:0]       kbyte;
    logic             go;
    logic             adv;

    assign go  = (state == ST_IDLE) && start;
    assign adv = (state == ST_WR_J);

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES),
        .KEY_W     (KEY_W)
    ) u_ksel (
        .clk     (clk),
        .reset   (reset),
        .clear   (go),
        .advance (adv),
        .key     (key_q),
        .kbyte   (kbyte)
    );

    // KSA control: init fill, then 8-cycle read/read/swap per i.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            key_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_q <= secret_key;
                        i     <= '0;
                        j     <= '0;
                        state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    i <= i + 8'd1;
                    if (i == I_LAST)
                        state <= ST_RD_I;
                end
                ST_RD_I:   state <= ST_WAIT_I;
                ST_WAIT_I: state <= ST_CAP_I;
                ST_CAP_I: begin
                    si    <= q_data;
                    j     <= j + q_data + kbyte;
                    state <= ST_RD_J;
                end
                ST_RD_J:   state <= ST_WAIT_J;
                ST_WAIT_J: state <= ST_CAP_J;
                ST_CAP_J: begin
                    sj    <= q_data;
                    state <= ST_WR_I;
                end
                ST_WR_I:   state <= ST_WR_J;
                ST_WR_J: begin
                    i <= i + 8'd1;
                    if (i == I_LAST)
                        state <= ST_DONE;
                    else
                        state <= ST_RD_I;
                end
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode of RAM port, ownership and done pulse.
    always_comb begin
        address         = '0;
        data            = '0;
        wen             = 1'b0;
        ksa_mem_handler = (state != ST_IDLE) && (state != ST_DONE);
        finish          = (state == ST_DONE);
        unique case (state)
            ST_INIT: begin
                address = i;
                data    = i;
                wen     = 1'b1;
            end
            ST_RD_I: address = i;
            ST_RD_J: address = j;
            ST_WR_I: begin
                address = i;
                data    = sj;
                wen     = 1'b1;
            end
            ST_WR_J: begin
                address = j;
                data    = si;
                wen     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RC4_KSA_CYCLE_COUNT_EN
    // Run length counter, held after DONE until the next start.
    always_ff @(posedge clk) begin
        if (reset)
            cycle_count <= '0;
        else if (go)
            cycle_count <= '0;
        else if (state != ST_IDLE)
            cycle_count <= cycle_count + 16'd1;
    end
`endif

endmodule

// File: doc/rc4_key_schedule.md
Name: rc4_key_schedule

Overview:
- Upstream stage of the RC4 PRGA/decrypt block.
- Runs the RC4 key-scheduling algorithm (KSA) on the shared 256x8 S working RAM:
  - init phase: writes S[i] = i;
  - shuffle phase: j = j + S[i] + key[i mod KEY_BYTES], then swaps S[i] and S[j].
- On completion it pulses finish; the top level then starts the decrypt stage on the same S RAM.

Parameters:
- KEY_BYTES, 3: number of secret key bytes.
- KEY_W, 24: secret_key width, fixed at 8*KEY_BYTES.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: level sampled in IDLE only; high in IDLE begins a run.
- secret_key, input, KEY_W: key; key[0] = secret_key[KEY_W-1 -: 8] (MSB byte first).
- q_data, input, 8: S RAM read data.
- address, output, 8: S RAM address.
- data, output, 8: S RAM write data.
- wen, output, 1: S RAM write enable.
- ksa_mem_handler, output, 1: high while this block owns the S RAM, for the top-level mux.
- finish, output, 1: one-cycle done pulse.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - wen=0, address=0, data=0, finish=0, ksa_mem_handler=0.
  - Internal i, j, key register cleared.
- RAM contract:
  - The address presented in cycle N is valid on q_data in cycle N+2.
  - A write occurs at the clk edge ending a cycle in which wen=1.
- Outputs are Moore, decoded from the registered state and the i/j/temp registers.
- IDLE:
  - On start=1, latch secret_key into key_q, set i=0 and j=0, and go to INIT.
  - Changes to secret_key after this point are ignored.
- INIT, cycles 0..255:
  - address=i, data=i, wen=1; i increments each cycle.
  - When i=255 is written, i wraps to 0 and the block goes to RD_I.
- Shuffle loop, 8 cycles per i:
  - RD_I: address=i.
  - WAIT_I.
  - CAP_I: si <= q_data; j <= j + q_data + key_q byte (i mod KEY_BYTES), mod 256.
  - RD_J: address=j.
  - WAIT_J.
  - CAP_J: sj <= q_data.
  - WR_I: address=i, data=sj, wen=1.
  - WR_J: address=j, data=si, wen=1; i <= i+1. If i was 255, go to DONE; otherwise go to RD_I.
- Key index: a mod-KEY_BYTES counter that advances with i. No divider.
- DONE:
  - finish=1 for exactly one cycle, then IDLE.
  - ksa_mem_handler is 0 in DONE.
- ksa_mem_handler is 1 in every INIT and shuffle state.
- Latency: with cycle 0 = the first INIT cycle, the shuffle spans cycles 256..2303 and finish is high in cycle 2304.
- Boundary conditions:
  - i==j: both writes target the same address with the original value; the result is unchanged. This is legal.
  - j arithmetic is 8-bit and wraps silently.
  - start while busy or in DONE is ignored.
  - start held high continuously: the block re-runs from the IDLE cycle after DONE.
  - reset mid-run: the next cycle is IDLE with wen=0. RAM contents are undefined and no finish pulse occurs.
  - reset and start in the same cycle: reset wins.
- wen is never 1 outside INIT, WR_I and WR_J.

Optional Feature:
- Macro: RC4_KSA_CYCLE_COUNT_EN.
- When defined:
  - Adds output cycle_count[15:0]: cleared on leaving IDLE and incremented every non-IDLE cycle.
  - The value holds after DONE until the next start or reset.
  - It must read 2305 in the cycle after finish.
- When undefined: the port and counter are absent. Functional behaviour is identical.

Decomposition:
- Shared package rc4_pkg holds:
  - the state enum type for the KSA FSM;
  - constants S_SIZE=256, RAM_RD_LAT=2, KEY_BYTES_DEFAULT=3;
  - a key_byte(key, idx) function.
- One sub-module is natural: rc4_key_byte_sel, a registered mod-KEY_BYTES index counter plus byte mux. Everything else stays in the single FSM module.

Test Plan:
- Init check:
  - Stimulus: start pulse with key 0x000000; bench RAM model with 2-cycle read latency.
  - Response: cycles 0..255 show wen=1 with address=data=0..255.
- Early swaps, key 0x000000:
  - i=0 and i=1 are self-swaps.
  - At i=2, j=3: after that iteration, S[2]=3 and S[3]=2.
- Full run, key 0x000249:
  - Final 256-byte S equals the software KSA golden model.
  - finish high exactly in cycle 2304, for one cycle only.
- Start while busy:
  - Stimulus: pulse start at cycle 100.
  - Response: no restart, no key re-latch, finish still at cycle 2304.
- Reset mid-run:
  - Stimulus: reset at cycle 1000.
  - Response: next cycle wen=0, ksa_mem_handler=0, finish=0; a subsequent start completes a correct run.
- Key independence and counter:
  - secret_key changed after the start cycle does not alter the result.
  - With RC4_KSA_CYCLE_COUNT_EN, cycle_count=2305 after finish.
